cache_refill_ctrl: RTL and testbench

CACHE_REFILL_CTRL -- requirements
Module: cache_refill_ctrl

---
 rtl/mem_pkg.sv | 19 +
 rtl/sat_counter.sv | 38 +++
 rtl/cache_refill_ctrl.sv | 162 ++++++++++++++++
 tb/tb_cache_refill_ctrl.sv | 445 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// mem_pkg
// Shared definitions for the cache refill controller: default bus widths,
// statistic counter width, wait counter width and the controller FSM states.
package mem_pkg;

    localparam int unsigned DefDataWidth = 32;
    localparam int unsigned DefAddrWidth = 8;
    localparam int unsigned StatWidth    = 16;
    // Wide enough for the largest legal MEM_LATENCY-1 (14).
    localparam int unsigned WaitWidth    = 4;

    typedef enum logic [1:0] {
        StIdle,
        StLookup,
        StMemWait,
        StFill
    } refill_state_e;

endpackage

// File: rtl/sat_counter.sv
// sat_counter
// Up-counter that sticks at all-ones instead of wrapping.
// Ports:
//   clk_i   - clock
//   rst_i   - asynchronous active-high reset, loads ResetValue
//   inc_i   - increment request for this cycle
//   count_o - current count
module sat_counter #(
    parameter int unsigned       Width      = 16,
    parameter logic [Width-1:0]  ResetValue = '0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             inc_i,
    output logic [Width-1:0] count_o
);

    logic [Width-1:0] count_d;
    logic [Width-1:0] count_q;

    always_comb begin
        count_d = count_q;
        if (inc_i && (count_q != {Width{1'b1}})) begin
            count_d = count_q + Width'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= ResetValue;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/cache_refill_ctrl.sv
// cache_refill_ctrl
// Single-outstanding-request L1 controller. Stores write through to both the
// cache and the next level; loads are served from the cache on a hit or
// fetched from the next level on a miss and then filled into the cache.
// Ports:
//   clk, rst                       - clock, asynchronous active-high reset
//   req_*                          - core request (valid/ready handshake)
//   resp_valid, resp_read_data     - one-cycle response pulse and held data
//   cache_*                        - L1 array access (hit/data are combinational)
//   mem_*                          - next-level access, read data valid
//                                    MEM_LATENCY cycles after mem_read_en
//   hit_count, miss_count          - saturating load statistics
// MEM_LATENCY must lie in 1..15.
module cache_refill_ctrl
    import mem_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = DefDataWidth,
    parameter int unsigned ADDR_WIDTH  = DefAddrWidth,
    parameter int unsigned MEM_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_address,
    input  logic [DATA_WIDTH-1:0] req_write_data,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_read_data,
    output logic                  cache_write_en,
    output logic [ADDR_WIDTH-1:0] cache_address,
    output logic [DATA_WIDTH-1:0] cache_write_data,
    input  logic                  cache_hit,
    input  logic [DATA_WIDTH-1:0] cache_read_data,
    output logic                  mem_read_en,
    output logic                  mem_write_en,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_write_data,
    input  logic [DATA_WIDTH-1:0] mem_read_data,
    output logic [15:0]           hit_count,
    output logic [15:0]           miss_count
);

    localparam logic [WaitWidth-1:0] WaitLoad = WaitWidth'(MEM_LATENCY - 1);

    refill_state_e         state_d, state_q;
    logic                  write_d, write_q;
    logic [ADDR_WIDTH-1:0] addr_d, addr_q;
    // Holds store data, then the fetched line word once a miss returns.
    logic [DATA_WIDTH-1:0] data_d, data_q;
    logic [WaitWidth-1:0]  wait_d, wait_q;
    logic                  resp_valid_d, resp_valid_q;
    logic [DATA_WIDTH-1:0] resp_data_d, resp_data_q;
    logic                  hit_inc;
    logic                  miss_inc;

    always_comb begin
        state_d      = state_q;
        write_d      = write_q;
        addr_d       = addr_q;
        data_d       = data_q;
        wait_d       = wait_q;
        resp_valid_d = 1'b0;
        resp_data_d  = resp_data_q;
        hit_inc      = 1'b0;
        miss_inc     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    write_d = req_write;
                    addr_d  = req_address;
                    data_d  = req_write_data;
                    state_d = StLookup;
                end
            end
            StLookup: begin
                if (write_q) begin
                    resp_valid_d = 1'b1;
                    resp_data_d  = data_q;
                    state_d      = StIdle;
                end else if (cache_hit) begin
                    resp_valid_d = 1'b1;
                    resp_data_d  = cache_read_data;
                    hit_inc      = 1'b1;
                    state_d      = StIdle;
                end else begin
                    miss_inc = 1'b1;
                    wait_d   = WaitLoad;
                    state_d  = StMemWait;
                end
            end
            StMemWait: begin
                // The read was issued during LOOKUP, so data lands when the count hits 0.
                if (wait_q == '0) begin
                    data_d  = mem_read_data;
                    state_d = StFill;
                end else begin
                    wait_d = wait_q - WaitWidth'(1);
                end
            end
            StFill: begin
                resp_valid_d = 1'b1;
                resp_data_d  = data_q;
                state_d      = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            write_q      <= 1'b0;
            addr_q       <= '0;
            data_q       <= '0;
            wait_q       <= '0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
        end else begin
            state_q      <= state_d;
            write_q      <= write_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            wait_q       <= wait_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
        end
    end

    // Strobes decode the registered state; the miss read also needs the live hit.
    assign req_ready        = (state_q == StIdle);
    assign cache_write_en   = ((state_q == StLookup) && write_q) || (state_q == StFill);
    assign mem_write_en     = (state_q == StLookup) && write_q;
    assign mem_read_en      = (state_q == StLookup) && !write_q && !cache_hit;
    assign cache_address    = addr_q;
    assign cache_write_data = data_q;
    assign mem_address      = addr_q;
    assign mem_write_data   = data_q;
    assign resp_valid       = resp_valid_q;
    assign resp_read_data   = resp_data_q;

    sat_counter #(
        .Width      (StatWidth),
        .ResetValue (16'h0000)
    ) u_hit_counter (
        .clk_i   (clk),
        .rst_i   (rst),
        .inc_i   (hit_inc),
        .count_o (hit_count)
    );

    sat_counter #(
        .Width      (StatWidth),
        .ResetValue (16'h0000)
    ) u_miss_counter (
        .clk_i   (clk),
        .rst_i   (rst),
        .inc_i   (miss_inc),
        .count_o (miss_count)
    );

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// tb_cache_refill_ctrl
// Directed vector table, hand-written corner sequences and a randomized phase
// checked against a transaction-level cache/memory model.
module tb_cache_refill_ctrl;

    localparam int unsigned DW  = 32;
    localparam int unsigned AW  = 8;
    localparam int unsigned LAT = 3;

    logic          clk;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic          req_write;
    logic [AW-1:0] req_address;
    logic [DW-1:0] req_write_data;
    logic          resp_valid;
    logic [DW-1:0] resp_read_data;
    logic          cache_write_en;
    logic [AW-1:0] cache_address;
    logic [DW-1:0] cache_write_data;
    logic          cache_hit;
    logic [DW-1:0] cache_read_data;
    logic          mem_read_en;
    logic          mem_write_en;
    logic [AW-1:0] mem_address;
    logic [DW-1:0] mem_write_data;
    logic [DW-1:0] mem_read_data;
    logic [15:0]   hit_count;
    logic [15:0]   miss_count;

    logic          sat_inc;
    logic [15:0]   sat_count;

    cache_refill_ctrl #(
        .DATA_WIDTH  (DW),
        .ADDR_WIDTH  (AW),
        .MEM_LATENCY (LAT)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_write        (req_write),
        .req_address      (req_address),
        .req_write_data   (req_write_data),
        .resp_valid       (resp_valid),
        .resp_read_data   (resp_read_data),
        .cache_write_en   (cache_write_en),
        .cache_address    (cache_address),
        .cache_write_data (cache_write_data),
        .cache_hit        (cache_hit),
        .cache_read_data  (cache_read_data),
        .mem_read_en      (mem_read_en),
        .mem_write_en     (mem_write_en),
        .mem_address      (mem_address),
        .mem_write_data   (mem_write_data),
        .mem_read_data    (mem_read_data),
        .hit_count        (hit_count),
        .miss_count       (miss_count)
    );

    // Standalone counter preloaded near the top to reach saturation quickly.
    sat_counter #(
        .Width      (16),
        .ResetValue (16'hFFFE)
    ) u_sat (
        .clk_i   (clk),
        .rst_i   (rst),
        .inc_i   (sat_inc),
        .count_o (sat_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks;
    int passes;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // ---------------- environment: L1 array and next-level memory ----------------
    logic          env_mode;
    logic          env_clear;
    logic          vec_hit;
    logic [DW-1:0] vec_cache_data;
    logic [DW-1:0] vec_mem_data;
    logic          env_valid [256];
    logic [DW-1:0] env_data  [256];
    logic [DW-1:0] env_mem   [256];
    logic          pend_active;
    int            lat_left;
    logic [AW-1:0] pend_addr;

    function automatic logic [31:0] mem_init(input int a);
        return (32'h9E37_79B9 * 32'(a + 1)) ^ 32'h5A5A_0000;
    endfunction

    always @(posedge clk) begin
        if (env_clear) begin
            for (int i = 0; i < 256; i++) begin
                env_valid[i] <= 1'b0;
                env_data[i]  <= '0;
                env_mem[i]   <= mem_init(i);
            end
            pend_active <= 1'b0;
            lat_left    <= 0;
            pend_addr   <= '0;
        end else begin
            if (cache_write_en) begin
                env_valid[cache_address] <= 1'b1;
                env_data[cache_address]  <= cache_write_data;
            end
            if (mem_write_en) env_mem[mem_address] <= mem_write_data;
            if (mem_read_en) begin
                pend_active <= 1'b1;
                lat_left    <= int'(LAT) - 1;
                pend_addr   <= mem_address;
            end else if (pend_active) begin
                if (lat_left == 0) pend_active <= 1'b0;
                else lat_left <= lat_left - 1;
            end
        end
    end

    always_comb begin
        if (env_mode) begin
            cache_hit       = env_valid[cache_address];
            cache_read_data = env_data[cache_address];
            mem_read_data   = (pend_active && lat_left == 0) ? env_mem[pend_addr] : 32'hBAD0_BAD0;
        end else begin
            cache_hit       = vec_hit;
            cache_read_data = vec_cache_data;
            mem_read_data   = vec_mem_data;
        end
    end

    // ---------------- strobe monitor ----------------
    int            cwe_n, mwe_n, mre_n, resp_n;
    logic [AW-1:0] cwe_addr, mwe_addr, mre_addr;
    logic [DW-1:0] cwe_data, mwe_data;

    always @(negedge clk) begin
        if (env_clear) begin
            cwe_n  <= 0;
            mwe_n  <= 0;
            mre_n  <= 0;
            resp_n <= 0;
        end else begin
            if (cache_write_en) begin
                cwe_n    <= cwe_n + 1;
                cwe_addr <= cache_address;
                cwe_data <= cache_write_data;
            end
            if (mem_write_en) begin
                mwe_n    <= mwe_n + 1;
                mwe_addr <= mem_address;
                mwe_data <= mem_write_data;
            end
            if (mem_read_en) begin
                mre_n    <= mre_n + 1;
                mre_addr <= mem_address;
            end
            if (resp_valid) resp_n <= resp_n + 1;
        end
    end

    // Issues one request; lat counts cycles from the handshake cycle to resp_valid.
    task automatic run_req(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                           output int lat, output logic [DW-1:0] rd);
        int n;
        lat = -1;
        rd  = '0;
        @(negedge clk);
        req_valid      = 1'b1;
        req_write      = w;
        req_address    = a;
        req_write_data = d;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            check("req_ready_timeout", {31'b0, req_ready}, 32'd1);
            req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (resp_valid) begin
                lat = k;
                rd  = resp_read_data;
                break;
            end
        end
    endtask

    typedef struct {
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic          hit;
        logic [DW-1:0] cdata;
        logic [DW-1:0] mdata;
        logic [DW-1:0] exp_data;
        int            exp_lat;
        logic [15:0]   exp_hits;
        logic [15:0]   exp_misses;
        int            exp_cwe;
        int            exp_mwe;
        int            exp_mre;
    } vec_t;

    vec_t vecs [6];

    // Transaction-level model state for the random phase.
    logic          m_valid [256];
    logic [DW-1:0] m_data  [256];
    logic [DW-1:0] m_mem   [256];

    initial begin
        int            lat;
        int            s_cwe, s_mwe, s_mre, s_resp;
        int            m_hits, m_misses, exp_lat;
        logic [DW-1:0] rd, exp_d, d;
        logic [AW-1:0] a;
        logic          w;
        int            nresp;
        int            r_k [2];
        logic [DW-1:0] r_d [2];
        logic          r_rdy;

        checks = 0;
        passes = 0;
        rst = 1'b1;
        env_clear = 1'b1;
        env_mode = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_address = '0;
        req_write_data = '0;
        vec_hit = 1'b0;
        vec_cache_data = '0;
        vec_mem_data = '0;
        sat_inc = 1'b0;
        r_rdy = 1'b0;

        vecs[0] = '{1'b1, 8'h10, 32'hDEADBEEF, 1'b0, 32'h0, 32'h0,
                    32'hDEADBEEF, 2, 16'd0, 16'd0, 1, 1, 0};
        vecs[1] = '{1'b0, 8'h10, 32'h0, 1'b1, 32'h12345678, 32'h0,
                    32'h12345678, 2, 16'd1, 16'd0, 0, 0, 0};
        vecs[2] = '{1'b0, 8'h20, 32'h0, 1'b0, 32'h0, 32'hCAFEF00D,
                    32'hCAFEF00D, int'(LAT) + 3, 16'd1, 16'd1, 1, 0, 1};
        vecs[3] = '{1'b1, 8'h33, 32'h0000_0000, 1'b1, 32'h1, 32'h0,
                    32'h0000_0000, 2, 16'd1, 16'd1, 1, 1, 0};
        vecs[4] = '{1'b0, 8'hFF, 32'h0, 1'b1, 32'hFFFFFFFF, 32'h0,
                    32'hFFFFFFFF, 2, 16'd2, 16'd1, 0, 0, 0};
        vecs[5] = '{1'b0, 8'h00, 32'h0, 1'b0, 32'h0, 32'h0BADF00D,
                    32'h0BADF00D, int'(LAT) + 3, 16'd2, 16'd2, 1, 0, 1};

        // ---- reset state ----
        repeat (3) @(negedge clk);
        check("rst_req_ready", {31'b0, req_ready}, 32'd1);
        check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        check("rst_resp_data", resp_read_data, 32'd0);
        check("rst_hit_count", {16'b0, hit_count}, 32'd0);
        check("rst_miss_count", {16'b0, miss_count}, 32'd0);
        check("rst_enables", {29'b0, cache_write_en, mem_write_en, mem_read_en}, 32'd0);
        check("rst_sat_count", {16'b0, sat_count}, 32'h0000_FFFE);
        rst = 1'b0;
        env_clear = 1'b0;
        repeat (2) @(negedge clk);

        // ---- directed vector table ----
        for (int i = 0; i < 6; i++) begin
            vec_hit = vecs[i].hit;
            vec_cache_data = vecs[i].cdata;
            vec_mem_data = vecs[i].mdata;
            s_cwe = cwe_n;
            s_mwe = mwe_n;
            s_mre = mre_n;
            s_resp = resp_n;
            run_req(vecs[i].wr, vecs[i].addr, vecs[i].wdata, lat, rd);
            check($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
            check($sformatf("v%0d_resp_data", i), rd, vecs[i].exp_data);
            repeat (3) @(negedge clk);
            check($sformatf("v%0d_resp_data_held", i), resp_read_data, vecs[i].exp_data);
            check($sformatf("v%0d_hit_count", i), {16'b0, hit_count}, {16'b0, vecs[i].exp_hits});
            check($sformatf("v%0d_miss_count", i), {16'b0, miss_count},
                  {16'b0, vecs[i].exp_misses});
            check($sformatf("v%0d_resp_pulses", i), 32'(resp_n - s_resp), 32'd1);
            check($sformatf("v%0d_cwe_pulses", i), 32'(cwe_n - s_cwe), 32'(vecs[i].exp_cwe));
            check($sformatf("v%0d_mwe_pulses", i), 32'(mwe_n - s_mwe), 32'(vecs[i].exp_mwe));
            check($sformatf("v%0d_mre_pulses", i), 32'(mre_n - s_mre), 32'(vecs[i].exp_mre));
            if (vecs[i].exp_cwe != 0) begin
                check($sformatf("v%0d_cwe_addr", i), {24'b0, cwe_addr}, {24'b0, vecs[i].addr});
                check($sformatf("v%0d_cwe_data", i), cwe_data, vecs[i].exp_data);
            end
            if (vecs[i].exp_mwe != 0) begin
                check($sformatf("v%0d_mwe_addr", i), {24'b0, mwe_addr}, {24'b0, vecs[i].addr});
                check($sformatf("v%0d_mwe_data", i), mwe_data, vecs[i].wdata);
            end
            if (vecs[i].exp_mre != 0) begin
                check($sformatf("v%0d_mre_addr", i), {24'b0, mre_addr}, {24'b0, vecs[i].addr});
            end
        end

        // ---- reset during MEM_WAIT aborts the miss ----
        vec_hit = 1'b0;
        vec_mem_data = 32'h7777_7777;
        s_cwe = cwe_n;
        s_resp = resp_n;
        @(negedge clk);
        req_valid = 1'b1;
        req_write = 1'b0;
        req_address = 8'h44;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_ready_in_reset", {31'b0, req_ready}, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        check("abort_no_fill", 32'(cwe_n - s_cwe), 32'd0);
        check("abort_no_resp", 32'(resp_n - s_resp), 32'd0);
        check("abort_hit_count", {16'b0, hit_count}, 32'd0);
        check("abort_miss_count", {16'b0, miss_count}, 32'd0);
        run_req(1'b1, 8'h55, 32'hA5A5_5A5A, lat, rd);
        check("after_abort_latency", 32'(lat), 32'd2);
        check("after_abort_data", rd, 32'hA5A5_5A5A);

        // ---- back-to-back with req_valid held high ----
        vec_hit = 1'b1;
        vec_cache_data = 32'h2222_2222;
        nresp = 0;
        r_k[0] = -1;
        r_k[1] = -1;
        r_d[0] = '0;
        r_d[1] = '0;
        @(negedge clk);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_address = 8'h40;
        req_write_data = 32'h1111_1111;
        check("b2b_first_ready", {31'b0, req_ready}, 32'd1);
        @(posedge clk);
        #1;
        req_write = 1'b0;
        req_address = 8'h41;
        for (int k = 1; k <= 20 && nresp < 2; k++) begin
            @(negedge clk);
            if (resp_valid) begin
                r_k[nresp] = k;
                r_d[nresp] = resp_read_data;
                if (nresp == 0) begin
                    r_rdy = req_ready;
                    @(posedge clk);
                    #1;
                    req_valid = 1'b0;
                end
                nresp++;
            end
        end
        req_valid = 1'b0;
        check("b2b_resp_count", 32'(nresp), 32'd2);
        check("b2b_ready_in_resp", {31'b0, r_rdy}, 32'd1);
        check("b2b_first_cycle", 32'(r_k[0]), 32'd2);
        check("b2b_first_data", r_d[0], 32'h1111_1111);
        check("b2b_second_cycle", 32'(r_k[1]), 32'd4);
        check("b2b_second_data", r_d[1], 32'h2222_2222);

        // ---- randomized traffic against the transaction model ----
        repeat (2) @(negedge clk);
        rst = 1'b1;
        env_clear = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        env_clear = 1'b0;
        env_mode = 1'b1;
        for (int i = 0; i < 256; i++) begin
            m_valid[i] = 1'b0;
            m_data[i] = '0;
            m_mem[i] = mem_init(i);
        end
        m_hits = 0;
        m_misses = 0;
        for (int t = 0; t < 150; t++) begin
            w = ($urandom_range(0, 2) == 0);
            a = 8'($urandom_range(0, 15));
            d = $urandom;
            if (w) begin
                exp_d = d;
                exp_lat = 2;
                m_valid[a] = 1'b1;
                m_data[a] = d;
                m_mem[a] = d;
            end else if (m_valid[a]) begin
                exp_d = m_data[a];
                exp_lat = 2;
                m_hits++;
            end else begin
                exp_d = m_mem[a];
                exp_lat = int'(LAT) + 3;
                m_misses++;
                m_valid[a] = 1'b1;
                m_data[a] = exp_d;
            end
            run_req(w, a, d, lat, rd);
            check($sformatf("rnd%0d_latency", t), 32'(lat), 32'(exp_lat));
            check($sformatf("rnd%0d_data", t), rd, exp_d);
            check($sformatf("rnd%0d_hit_count", t), {16'b0, hit_count}, 32'(m_hits));
            check($sformatf("rnd%0d_miss_count", t), {16'b0, miss_count}, 32'(m_misses));
        end
        env_mode = 1'b0;

        // ---- saturation ----
        @(negedge clk);
        check("sat_start", {16'b0, sat_count}, 32'h0000_FFFE);
        sat_inc = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("sat_inc%0d", i), {16'b0, sat_count}, 32'h0000_FFFF);
        end
        sat_inc = 1'b0;
        @(negedge clk);
        check("sat_hold", {16'b0, sat_count}, 32'h0000_FFFF);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
